// File: rtl/core_mem_arbiter.sv
// Two-to-one arbiter sharing one external memory port between instruction fetch
// and data access: one outstanding transaction, round-robin, grant timeout.
module core_mem_arbiter #(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] inst,
  output logic        inst_stall,
  output logic        inst_access_fault,
  input  logic        req_mem,
  input  logic        wmem_o,
  input  logic [3:0]  wmask,
  input  logic [31:0] addr_o,
  input  logic [31:0] data_o,
  output logic [31:0] data_i,
  output logic        data_stall,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [2:0] {IDLE, I_ADDR, I_RESP, D_ADDR, D_RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(GNT_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_d, last_d_nxt;
  logic [7:0]  gnt_cnt, gnt_cnt_nxt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wmask;
  logic        cap_we;
  logic        capture_i, capture_d;
  logic        inst_done, data_done;

  always_comb begin
    state_nxt         = state;
    last_d_nxt        = last_d;
    gnt_cnt_nxt       = gnt_cnt;
    capture_i         = 1'b0;
    capture_d         = 1'b0;
    inst_done         = 1'b0;
    data_done         = 1'b0;
    inst_access_fault = 1'b0;
    data_err          = 1'b0;
    mem_req           = 1'b0;
    case (state)
      IDLE: begin
        // On contention last_d selects fetch, otherwise data wins.
        if (if_req && (!req_mem || last_d)) begin
          capture_i   = 1'b1;
          state_nxt   = I_ADDR;
          last_d_nxt  = 1'b0;
          gnt_cnt_nxt = '0;
        end else if (req_mem) begin
          capture_d   = 1'b1;
          state_nxt   = D_ADDR;
          last_d_nxt  = 1'b1;
          gnt_cnt_nxt = '0;
        end
      end
      I_ADDR, D_ADDR: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_nxt   = (state == I_ADDR) ? I_RESP : D_RESP;
          gnt_cnt_nxt = '0;
        end else if (gnt_cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          gnt_cnt_nxt = '0;
          if (state == I_ADDR) begin
            inst_done         = 1'b1;
            inst_access_fault = 1'b1;
          end else begin
            data_done = 1'b1;
            data_err  = 1'b1;
          end
        end else begin
          gnt_cnt_nxt = gnt_cnt + 8'd1;
        end
      end
      I_RESP: begin
        // A response for a PC the core has since left is dropped; IDLE refetches.
        if (mem_rvalid) begin
          state_nxt = IDLE;
          if (if_addr == cap_addr) begin
            inst_done         = 1'b1;
            inst_access_fault = mem_err;
          end
        end
      end
      D_RESP: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
          data_done = 1'b1;
          data_err  = mem_err;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      gnt_cnt   <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wmask <= '0;
      cap_we    <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      gnt_cnt <= gnt_cnt_nxt;
      if (capture_i) begin
        cap_addr  <= if_addr;
        cap_wdata <= '0;
        cap_wmask <= '1;
        cap_we    <= 1'b0;
      end else if (capture_d) begin
        cap_addr  <= addr_o;
        cap_wdata <= data_o;
        cap_wmask <= wmem_o ? wmask : 4'hF;
        cap_we    <= wmem_o;
      end
    end
  end

  assign mem_addr   = cap_addr;
  assign mem_wdata  = cap_wdata;
  assign mem_wmask  = cap_wmask;
  assign mem_we     = cap_we;
  assign inst       = mem_rdata;
  assign data_i     = mem_rdata;
  assign inst_stall = if_req & ~inst_done;
  assign data_stall = req_mem & ~data_done;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed cycle table, reset sequences, and a
// randomized run against a transaction-level model of core and memory.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, req_mem, wmem_o;
  logic [31:0] if_addr, addr_o, data_o;
  logic [3:0]  wmask;
  logic [31:0] inst, data_i;
  logic        inst_stall, inst_access_fault, data_stall, data_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  core_mem_arbiter #(.GNT_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .inst(inst), .inst_stall(inst_stall),
    .inst_access_fault(inst_access_fault),
    .req_mem(req_mem), .wmem_o(wmem_o), .wmask(wmask), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_i), .data_stall(data_stall), .data_err(data_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One row per clock cycle: inputs driven, then outputs expected in that cycle.
  typedef struct {
    logic [31:0] ifr, ia, dr, we, wm, da, dw, g, rv, rd, er;
    logic [31:0] e_req, e_addr, e_we, e_wm, e_wd, e_is, e_ds, e_if, e_de, e_ci, e_cd;
  } vec_t;
  vec_t tbl[$];

  typedef enum {P_IDLE, P_ADDR, P_RESP} ph_t;
  ph_t         ph;
  bit          f_pend, d_pend, d_we, last_data, srv_data, x_we, f_done, d_done;
  logic [31:0] f_addr, d_addr, d_wdata, x_addr, x_wdata;
  logic [3:0]  d_mask, x_mask;
  int unsigned f_gap, d_gap, gdly, rdly;

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; req_mem = 1'b0; wmem_o = 1'b0; wmask = '0;
    addr_o = '0; data_o = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  initial begin
    //            ifr ia      dr we wm  da    dw           g rv rd       er  req addr  we wm  wd           is ds if de ci cd
    tbl.push_back('{1,'h100,  0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           1,0,0,0,0,0}); // single fetch
    tbl.push_back('{1,'h100,  0,0,0,  0,    0,           1,0,0,       0,  1,'h100,  0,'hF,0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h100,  0,0,0,  0,    0,           0,1,'h13,    0,  0,0,      0,0,  0,           0,0,0,0,1,0});
    tbl.push_back('{0,0,      0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           0,0,0,0,0,0});
    tbl.push_back('{1,'h300,  1,1,3,  'h20, 'hDEADBEEF,  0,0,0,       0,  0,0,      0,0,  0,           1,1,0,0,0,0}); // contention: data first
    tbl.push_back('{1,'h300,  1,1,3,  'h20, 'hDEADBEEF,  1,0,0,       0,  1,'h20,   1,3,  'hDEADBEEF,  1,1,0,0,0,0});
    tbl.push_back('{1,'h300,  1,1,3,  'h20, 'hDEADBEEF,  0,1,'h1234,  0,  0,0,      0,0,  0,           1,0,0,0,0,1});
    tbl.push_back('{1,'h300,  1,0,0,  'h24, 0,           0,0,0,       0,  0,0,      0,0,  0,           1,1,0,0,0,0}); // then fetch
    tbl.push_back('{1,'h300,  1,0,0,  'h24, 0,           1,0,0,       0,  1,'h300,  0,'hF,0,           1,1,0,0,0,0});
    tbl.push_back('{1,'h300,  1,0,0,  'h24, 0,           0,1,'hA,     0,  0,0,      0,0,  0,           0,1,0,0,1,0});
    tbl.push_back('{1,'h304,  1,0,0,  'h24, 0,           0,0,0,       0,  0,0,      0,0,  0,           1,1,0,0,0,0}); // then data
    tbl.push_back('{1,'h304,  1,0,0,  'h24, 0,           1,0,0,       0,  1,'h24,   0,'hF,0,           1,1,0,0,0,0});
    tbl.push_back('{1,'h304,  1,0,0,  'h24, 0,           0,1,'h55,    0,  0,0,      0,0,  0,           1,0,0,0,0,1});
    tbl.push_back('{0,0,      0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           0,0,0,0,0,0});
    tbl.push_back('{0,0,      1,0,0,  'h40, 0,           0,0,0,       0,  0,0,      0,0,  0,           0,1,0,0,0,0}); // error response
    tbl.push_back('{0,0,      1,0,0,  'h40, 0,           1,0,0,       0,  1,'h40,   0,'hF,0,           0,1,0,0,0,0});
    tbl.push_back('{0,0,      1,0,0,  'h40, 0,           0,1,'h77,    1,  0,0,      0,0,  0,           0,0,0,1,0,0});
    tbl.push_back('{0,0,      0,0,0,  0,    0,           1,1,'h77,    1,  0,0,      0,0,  0,           0,0,0,0,0,0});
    tbl.push_back('{1,'h500,  0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           1,0,0,0,0,0}); // grant timeout
    tbl.push_back('{1,'h500,  0,0,0,  0,    0,           0,0,0,       0,  1,'h500,  0,'hF,0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h500,  0,0,0,  0,    0,           0,0,0,       0,  1,'h500,  0,'hF,0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h500,  0,0,0,  0,    0,           0,0,0,       0,  1,'h500,  0,'hF,0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h500,  0,0,0,  0,    0,           0,0,0,       0,  1,'h500,  0,'hF,0,           0,0,1,0,0,0});
    tbl.push_back('{0,0,      0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           0,0,0,0,0,0});
    tbl.push_back('{1,'h100,  0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           1,0,0,0,0,0}); // redirect
    tbl.push_back('{1,'h100,  0,0,0,  0,    0,           1,0,0,       0,  1,'h100,  0,'hF,0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h200,  0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h200,  0,0,0,  0,    0,           0,1,'hBAD,   0,  0,0,      0,0,  0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h200,  0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h200,  0,0,0,  0,    0,           1,0,0,       0,  1,'h200,  0,'hF,0,           1,0,0,0,0,0});
    tbl.push_back('{1,'h200,  0,0,0,  0,    0,           0,1,'h600D,  0,  0,0,      0,0,  0,           0,0,0,0,1,0});
    tbl.push_back('{0,0,      0,0,0,  0,    0,           0,0,0,       0,  0,0,      0,0,  0,           0,0,0,0,0,0});

    // Reset values
    idle_inputs();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk); #1;
    chk1("rst mem_req", mem_req, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    chk32("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk1("rst inst_stall", inst_stall, 1'b1);
    chk1("rst data_stall", data_stall, 1'b0);
    chk1("rst fault", inst_access_fault, 1'b0);
    chk1("rst data_err", data_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if_req = tbl[i].ifr[0]; if_addr = tbl[i].ia; req_mem = tbl[i].dr[0]; wmem_o = tbl[i].we[0];
      wmask = tbl[i].wm[3:0]; addr_o = tbl[i].da; data_o = tbl[i].dw; mem_gnt = tbl[i].g[0];
      mem_rvalid = tbl[i].rv[0]; mem_rdata = tbl[i].rd; mem_err = tbl[i].er[0];
      #1;
      chk1($sformatf("v%0d mem_req", i), mem_req, tbl[i].e_req[0]);
      if (tbl[i].e_req[0]) begin
        chk32($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        chk1($sformatf("v%0d mem_we", i), mem_we, tbl[i].e_we[0]);
        chk32($sformatf("v%0d mem_wmask", i), {28'h0, mem_wmask}, tbl[i].e_wm);
        if (tbl[i].e_we[0]) chk32($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_wd);
      end
      chk1($sformatf("v%0d inst_stall", i), inst_stall, tbl[i].e_is[0]);
      chk1($sformatf("v%0d data_stall", i), data_stall, tbl[i].e_ds[0]);
      chk1($sformatf("v%0d inst_access_fault", i), inst_access_fault, tbl[i].e_if[0]);
      chk1($sformatf("v%0d data_err", i), data_err, tbl[i].e_de[0]);
      if (tbl[i].e_ci[0]) chk32($sformatf("v%0d inst", i), inst, tbl[i].rd);
      if (tbl[i].e_cd[0]) chk32($sformatf("v%0d data_i", i), data_i, tbl[i].rd);
    end

    // Reset while a data request waits for its grant
    @(negedge clk);
    idle_inputs(); req_mem = 1'b1; addr_o = 32'h80;
    @(negedge clk); #1;
    chk1("rstA mem_req before", mem_req, 1'b1);
    reset = 1'b1; #1;
    chk1("rstA mem_req after", mem_req, 1'b0);
    chk1("rstA data_stall", data_stall, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    // Reset while waiting for the response; a late rvalid must not complete
    @(negedge clk);
    mem_gnt = 1'b1; #1;
    chk1("rstR mem_req", mem_req, 1'b1);
    chk32("rstR mem_addr", mem_addr, 32'h80);
    @(negedge clk);
    mem_gnt = 1'b0; reset = 1'b1; #1;
    chk1("rstR mem_req in reset", mem_req, 1'b0);
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hFFFF; #1;
    chk1("rstR late rvalid stall", data_stall, 1'b1);
    chk1("rstR late rvalid err", data_err, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_gnt = 1'b1; #1;
    chk1("rstR reissue mem_req", mem_req, 1'b1);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99; #1;
    chk1("rstR done stall", data_stall, 1'b0);
    chk32("rstR done data_i", data_i, 32'h99);
    @(negedge clk);
    idle_inputs(); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against a transaction-level model
    ph = P_IDLE; last_data = 1'b0; srv_data = 1'b0;
    f_pend = 1'b0; d_pend = 1'b0; f_gap = 0; d_gap = 0; gdly = 0; rdly = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_mask = '0; d_we = 1'b0;
    x_addr = '0; x_wdata = '0; x_mask = '0; x_we = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if_req = f_pend; if_addr = f_addr;
      req_mem = d_pend; wmem_o = d_we; wmask = d_mask; addr_o = d_addr; data_o = d_wdata;
      mem_gnt    = (ph == P_ADDR) ? (gdly == 0) : ($urandom_range(0, 3) == 0);
      mem_rvalid = (ph == P_RESP) ? (rdly == 0) : ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
      mem_err    = ($urandom_range(0, 4) == 0);
      #1;
      f_done = (ph == P_RESP) && mem_rvalid && !srv_data;
      d_done = (ph == P_RESP) && mem_rvalid && srv_data;
      chk1("rnd mem_req", mem_req, ph == P_ADDR);
      if (ph == P_ADDR) begin
        chk32("rnd mem_addr", mem_addr, x_addr);
        chk1("rnd mem_we", mem_we, x_we);
        chk32("rnd mem_wmask", {28'h0, mem_wmask}, {28'h0, x_mask});
        if (x_we) chk32("rnd mem_wdata", mem_wdata, x_wdata);
      end
      chk1("rnd inst_stall", inst_stall, f_pend && !f_done);
      chk1("rnd data_stall", data_stall, d_pend && !d_done);
      chk1("rnd inst_access_fault", inst_access_fault, f_done && mem_err);
      chk1("rnd data_err", data_err, d_done && mem_err);
      if (f_done) chk32("rnd inst", inst, mem_rdata);
      if (d_done) chk32("rnd data_i", data_i, mem_rdata);

      case (ph)
        P_IDLE: if (f_pend || d_pend) begin
          srv_data  = d_pend && (!f_pend || !last_data);
          last_data = srv_data;
          x_addr    = srv_data ? d_addr : f_addr;
          x_we      = srv_data && d_we;
          x_mask    = x_we ? d_mask : 4'hF;
          x_wdata   = d_wdata;
          gdly      = $urandom_range(0, 2);
          ph        = P_ADDR;
        end
        P_ADDR: if (mem_gnt) begin
          ph   = P_RESP;
          rdly = $urandom_range(0, 3);
        end else gdly--;
        default: if (mem_rvalid) ph = P_IDLE; else rdly--;
      endcase
      if (f_done) begin f_pend = 1'b0; f_gap = $urandom_range(0, 2); end
      if (d_done) begin d_pend = 1'b0; d_gap = $urandom_range(0, 2); end
      if (!f_pend) begin
        if (f_gap > 0) f_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          f_pend = 1'b1;
          f_addr = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (!d_pend) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          d_pend  = 1'b1;
          d_we    = ($urandom_range(0, 1) == 1);
          d_mask  = 4'($urandom_range(1, 15));
          d_addr  = $urandom & 32'hFFFF_FFFC;
          d_wdata = $urandom;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
